// File: rtl/nav_pkg.sv
// Shared types and one-hot encodings for the nav_sequencer datapath controls.
package nav_pkg;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    CRUISE = 2'd2,
    ARRIVE = 2'd3
  } nav_state_e;

  localparam logic [3:0] MODE_ZERO    = 4'b0001;
  localparam logic [3:0] MODE_ATTACK  = 4'b0010;
  localparam logic [3:0] MODE_DEFENSE = 4'b0100;
  localparam logic [3:0] MODE_STEALTH = 4'b1000;

  localparam logic [3:0] POS_RESET = 4'b0001;
  localparam logic [3:0] POS_ACCUM = 4'b0010;

  localparam logic [1:0] CMD_NONE    = 2'b00;
  localparam logic [1:0] CMD_STEALTH = 2'b01;
  localparam logic [1:0] CMD_DEFENSE = 2'b10;
  localparam logic [1:0] CMD_ATTACK  = 2'b11;

endpackage

// File: rtl/nav_tier_select.sv
// Picks the fastest velocity tier allowed by the latched mode that cannot
// overshoot the remaining distance.
module nav_tier_select
  import nav_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int ATTACK_SPEED  = 16,
  parameter int DEFENSE_SPEED = 4,
  parameter int STEALTH_SPEED = 1
) (
  input  logic [WIDTH:0] i_dist,
  input  logic [1:0]     i_mode,
  output logic [3:0]     o_mode_sel
);

  localparam logic [WIDTH:0] W_ATTACK  = (WIDTH+1)'(ATTACK_SPEED);
  localparam logic [WIDTH:0] W_DEFENSE = (WIDTH+1)'(DEFENSE_SPEED);
  localparam logic [WIDTH:0] W_STEALTH = (WIDTH+1)'(STEALTH_SPEED);

  logic w_allow_attack;
  logic w_allow_defense;

  assign w_allow_attack  = (i_mode == CMD_ATTACK);
  assign w_allow_defense = (i_mode == CMD_ATTACK) || (i_mode == CMD_DEFENSE);

  // CMD_NONE falls through to the stealth tier.
  always_comb begin
    o_mode_sel = MODE_ZERO;
    if (i_dist == '0) begin
      o_mode_sel = MODE_ZERO;
    end else if (w_allow_attack && (i_dist >= W_ATTACK)) begin
      o_mode_sel = MODE_ATTACK;
    end else if (w_allow_defense && (i_dist >= W_DEFENSE)) begin
      o_mode_sel = MODE_DEFENSE;
    end else if (i_dist >= W_STEALTH) begin
      o_mode_sel = MODE_STEALTH;
    end
  end

endmodule

// File: rtl/nav_sequencer.sv
// Move sequencer driving an external position accumulator toward a target.
// Optional NAV_TIMEOUT_EN adds a CRUISE cycle limit with a sticky fault flag.
module nav_sequencer
  import nav_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int ATTACK_SPEED  = 16,
  parameter int DEFENSE_SPEED = 4,
  parameter int STEALTH_SPEED = 1,
  parameter int TIMEOUT       = 4095
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] target_pos,
  input  logic [1:0]       cmd_mode,
  input  logic [WIDTH-1:0] cur_pos,
  input  logic             abort,
  output logic [3:0]       mode_sel,
  output logic [3:0]       pos_sel,
  output logic             dir,
  output logic             busy,
  output logic             arrived,
  output logic             fault
);

  nav_state_e       r_state;
  nav_state_e       w_next;
  logic [WIDTH-1:0] r_target;
  logic [1:0]       r_mode;
  logic [WIDTH:0]   w_dist;
  logic             w_below;
  logic [3:0]       w_tier;
  logic             w_accept;
  logic             w_timeout;

  assign w_accept = cmd_valid && (r_state == IDLE);
  assign w_below  = (r_target < cur_pos);
  assign w_dist   = w_below ? ({1'b0, cur_pos} - {1'b0, r_target})
                            : ({1'b0, r_target} - {1'b0, cur_pos});

  nav_tier_select #(
    .WIDTH         (WIDTH),
    .ATTACK_SPEED  (ATTACK_SPEED),
    .DEFENSE_SPEED (DEFENSE_SPEED),
    .STEALTH_SPEED (STEALTH_SPEED)
  ) u_tier (
    .i_dist     (w_dist),
    .i_mode     (r_mode),
    .o_mode_sel (w_tier)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= INIT;
      r_target <= '0;
      r_mode   <= CMD_NONE;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_target <= target_pos;
        r_mode   <= cmd_mode;
      end
    end
  end

`ifdef NAV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_count;
  logic             r_fault;

  // Abort and arrival take precedence, so only a move still in flight times out.
  assign w_timeout = (r_state == CRUISE) && !abort && (w_dist != '0) &&
                     (r_count == CNT_W'(TIMEOUT - 1));
  assign fault     = r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_fault <= 1'b0;
    end else if (w_accept) begin
      r_count <= '0;
      r_fault <= 1'b0;
    end else if (r_state == CRUISE) begin
      r_count <= r_count + 1'b1;
      if (w_timeout) begin
        r_fault <= 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign fault     = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    arrived   = 1'b0;
    dir       = 1'b0;
    mode_sel  = MODE_ZERO;
    pos_sel   = POS_ACCUM;
    case (r_state)
      INIT: begin
        pos_sel = POS_RESET;
        w_next  = IDLE;
      end
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_next = CRUISE;
        end
      end
      CRUISE: begin
        busy     = 1'b1;
        dir      = w_below;
        mode_sel = w_tier;
        if (abort) begin
          w_next = IDLE;
        end else if (w_dist == '0) begin
          w_next = ARRIVE;
        end else if (w_timeout) begin
          w_next = IDLE;
        end
      end
      ARRIVE: begin
        busy    = 1'b1;
        arrived = 1'b1;
        w_next  = IDLE;
      end
      default: begin
        w_next = INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_nav_sequencer.sv
// Directed bench for nav_sequencer with a behavioural position accumulator
// closing the loop; build with NAV_TIMEOUT_EN to exercise the timeout path.
`timescale 1ns/1ps
module tb_nav_sequencer;
  import nav_pkg::*;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        abort     = 1'b0;
  logic [15:0] target_pos = '0;
  logic [1:0]  cmd_mode   = '0;
  logic [15:0] curPos     = '0;
  logic        cmdReady;
  logic [3:0]  modeSel;
  logic [3:0]  posSel;
  logic        dirOut;
  logic        busy;
  logic        arrived;
  logic        fault;

  logic        tbLoad    = 1'b0;
  logic [15:0] tbLoadVal = '0;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  nav_sequencer #(
    .WIDTH         (16),
    .ATTACK_SPEED  (16),
    .DEFENSE_SPEED (4),
    .STEALTH_SPEED (1),
    .TIMEOUT       (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmdReady),
    .target_pos (target_pos),
    .cmd_mode   (cmd_mode),
    .cur_pos    (curPos),
    .abort      (abort),
    .mode_sel   (modeSel),
    .pos_sel    (posSel),
    .dir        (dirOut),
    .busy       (busy),
    .arrived    (arrived),
    .fault      (fault)
  );

  // Axis accumulator: tier speeds are the bench's own constants (16/4/1).
  always @(posedge clk) begin
    if (tbLoad) begin
      curPos <= tbLoadVal;
    end else if (posSel == 4'b0001) begin
      curPos <= '0;
    end else if (posSel == 4'b0010) begin
      case (modeSel)
        4'b0010: curPos <= dirOut ? curPos - 16'd16 : curPos + 16'd16;
        4'b0100: curPos <= dirOut ? curPos - 16'd4  : curPos + 16'd4;
        4'b1000: curPos <= dirOut ? curPos - 16'd1  : curPos + 16'd1;
        default: curPos <= curPos;
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] tgt, input logic [1:0] mode);
    target_pos = tgt;
    cmd_mode   = mode;
    cmd_valid  = 1'b1;
  endtask

  task automatic loadPos(input logic [15:0] val);
    tbLoad    = 1'b1;
    tbLoadVal = val;
    tick();
    tbLoad = 1'b0;
  endtask

  task automatic cruiseStep(input string tag, input logic [3:0] expMode,
                            input logic [15:0] expCur, input logic expDir);
    checkOutput({tag, "_mode"},    32'(modeSel), 32'(expMode));
    checkOutput({tag, "_cur"},     32'(curPos),  32'(expCur));
    checkOutput({tag, "_dir"},     32'(dirOut),  32'(expDir));
    checkOutput({tag, "_arrived"}, 32'(arrived), 32'h0);
    tick();
  endtask

  initial begin
    // Reset state and INIT cycle
    #12;
    checkOutput("rst_mode",  32'(modeSel),  32'(MODE_ZERO));
    checkOutput("rst_pos",   32'(posSel),   32'(POS_RESET));
    checkOutput("rst_ready", 32'(cmdReady), 32'h0);
    checkOutput("rst_busy",  32'(busy),     32'h0);
    checkOutput("rst_arr",   32'(arrived),  32'h0);
    checkOutput("rst_fault", 32'(fault),    32'h0);
    checkOutput("rst_dir",   32'(dirOut),   32'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("init_pos",  32'(posSel),   32'(POS_RESET));
    tick();
    checkOutput("idle_pos",   32'(posSel),   32'(POS_ACCUM));
    checkOutput("idle_mode",  32'(modeSel),  32'(MODE_ZERO));
    checkOutput("idle_ready", 32'(cmdReady), 32'h1);

    // 0 -> 37 attack: 16,16,4,1 then arrival
    applyStimulus(16'd37, CMD_ATTACK);
    tick();
    cmd_valid = 1'b0;
    checkOutput("atk_busy",  32'(busy),     32'h1);
    checkOutput("atk_ready", 32'(cmdReady), 32'h0);
    cruiseStep("atk0", MODE_ATTACK,  16'd0,  1'b0);
    cruiseStep("atk1", MODE_ATTACK,  16'd16, 1'b0);
    cruiseStep("atk2", MODE_DEFENSE, 16'd32, 1'b0);
    cruiseStep("atk3", MODE_STEALTH, 16'd36, 1'b0);
    cruiseStep("atk4", MODE_ZERO,    16'd37, 1'b0);
    checkOutput("atk_arrived", 32'(arrived), 32'h1);
    checkOutput("atk_final",   32'(curPos),  32'd37);
    checkOutput("atk_abusy",   32'(busy),    32'h1);
    tick();
    checkOutput("atk_idle_arr",  32'(arrived),  32'h0);
    checkOutput("atk_idle_rdy",  32'(cmdReady), 32'h1);
    checkOutput("atk_idle_busy", 32'(busy),     32'h0);

    // 100 -> 95 defense, moving down
    loadPos(16'd100);
    applyStimulus(16'd95, CMD_DEFENSE);
    tick();
    cmd_valid = 1'b0;
    cruiseStep("def0", MODE_DEFENSE, 16'd100, 1'b1);
    cruiseStep("def1", MODE_STEALTH, 16'd96,  1'b1);
    cruiseStep("def2", MODE_ZERO,    16'd95,  1'b0);
    checkOutput("def_arrived", 32'(arrived), 32'h1);
    checkOutput("def_final",   32'(curPos),  32'd95);
    tick();

    // Abort in 3rd CRUISE cycle with cmd_valid held throughout
    applyStimulus(16'd200, CMD_ATTACK);
    tick();
    checkOutput("ab_c1_ready", 32'(cmdReady), 32'h0);
    checkOutput("ab_c1_mode",  32'(modeSel),  32'(MODE_ATTACK));
    target_pos = 16'd95;
    tick();
    checkOutput("ab_c2_ready", 32'(cmdReady), 32'h0);
    checkOutput("ab_c2_cur",   32'(curPos),   32'd111);
    tick();
    checkOutput("ab_c3_dir",   32'(dirOut),   32'h0);
    checkOutput("ab_c3_mode",  32'(modeSel),  32'(MODE_ATTACK));
    abort = 1'b1;
    tick();
    checkOutput("ab_idle_mode", 32'(modeSel),  32'(MODE_ZERO));
    checkOutput("ab_idle_arr",  32'(arrived),  32'h0);
    checkOutput("ab_idle_busy", 32'(busy),     32'h0);
    checkOutput("ab_idle_rdy",  32'(cmdReady), 32'h1);
    checkOutput("ab_idle_cur",  32'(curPos),   32'd143);

    // Held command now accepted; target equals position
    abort      = 1'b0;
    target_pos = 16'd143;
    cmd_mode   = CMD_STEALTH;
    tick();
    cmd_valid = 1'b0;
    checkOutput("eq_busy", 32'(busy),    32'h1);
    checkOutput("eq_mode", 32'(modeSel), 32'(MODE_ZERO));
    checkOutput("eq_arr0", 32'(arrived), 32'h0);
    tick();
    checkOutput("eq_arr1", 32'(arrived), 32'h1);
    checkOutput("eq_cur",  32'(curPos),  32'd143);
    tick();

    // Long stealth move: times out after 3 CRUISE cycles when enabled
    loadPos(16'd0);
    applyStimulus(16'd100, CMD_STEALTH);
    tick();
    cmd_valid = 1'b0;
    cruiseStep("to0", MODE_STEALTH, 16'd0, 1'b0);
    cruiseStep("to1", MODE_STEALTH, 16'd1, 1'b0);
    checkOutput("to2_fault", 32'(fault), 32'h0);
    cruiseStep("to2", MODE_STEALTH, 16'd2, 1'b0);
`ifdef NAV_TIMEOUT_EN
    checkOutput("to_fault", 32'(fault),    32'h1);
    checkOutput("to_busy",  32'(busy),     32'h0);
    checkOutput("to_rdy",   32'(cmdReady), 32'h1);
    checkOutput("to_arr",   32'(arrived),  32'h0);
    checkOutput("to_cur",   32'(curPos),   32'd3);
    applyStimulus(16'd3, CMD_STEALTH);
`else
    checkOutput("nto_fault", 32'(fault), 32'h0);
    checkOutput("nto_busy",  32'(busy),  32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("nto_idle", 32'(busy),   32'h0);
    checkOutput("nto_cur",  32'(curPos), 32'd4);
    applyStimulus(16'd4, CMD_STEALTH);
`endif
    tick();
    cmd_valid = 1'b0;
    checkOutput("clr_fault", 32'(fault),   32'h0);
    checkOutput("clr_busy",  32'(busy),    32'h1);
    tick();
    checkOutput("clr_arr",   32'(arrived), 32'h1);
    tick();

    // Reset asserted mid-move abandons it
    applyStimulus(16'd1000, CMD_ATTACK);
    tick();
    cmd_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("mr_busy",  32'(busy),     32'h0);
    checkOutput("mr_arr",   32'(arrived),  32'h0);
    checkOutput("mr_mode",  32'(modeSel),  32'(MODE_ZERO));
    checkOutput("mr_pos",   32'(posSel),   32'(POS_RESET));
    checkOutput("mr_ready", 32'(cmdReady), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("mr_idle_rdy", 32'(cmdReady), 32'h1);
    checkOutput("mr_idle_cur", 32'(curPos),   32'd0);
    checkOutput("mr_idle_arr", 32'(arrived),  32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nav_sequencer.md
NAV_SEQUENCER -- requirements
Module: nav_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16: position/target width.
REQ-002 SHALL have parameter ATTACK_SPEED, default 16: velocity magnitude of attack mode.
REQ-003 SHALL have parameter DEFENSE_SPEED, default 4: velocity magnitude of defense mode.
REQ-004 SHALL have parameter STEALTH_SPEED, default 1, fixed at 1: velocity magnitude of stealth mode.
REQ-005 SHALL have parameter TIMEOUT, default 4095: cycle limit while cruising, used only with NAV_TIMEOUT_EN.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 cmd_valid  input  1  new target offered.
REQ-009 cmd_ready  output  1  sequencer accepts a target.
REQ-010 target_pos  input  WIDTH  unsigned target position.
REQ-011 cmd_mode  input  2  requested top speed tier: 01 stealth, 10 defense, 11 attack; 00 treated as stealth.
REQ-012 cur_pos  input  WIDTH  registered axis position feedback.
REQ-013 abort  input  1  cancel the active move.
REQ-014 mode_sel  output  4  one-hot velocity select: 0001 zero, 0010 attack, 0100 defense, 1000 stealth.
REQ-015 pos_sel  output  4  one-hot position select: 0001 reset to 0, 0010 accumulate.
REQ-016 dir  output  1  1 = subtract velocity, 0 = add.
REQ-017 busy  output  1  move in progress.
REQ-018 arrived  output  1  one-cycle pulse on exact arrival.
REQ-019 fault  output  1  sticky timeout flag.

Function
REQ-020 States SHALL be INIT, IDLE, CRUISE and ARRIVE.
REQ-021 INIT SHALL drive pos_sel=0001 and mode_sel=0001 for exactly one cycle, then go to IDLE.
REQ-022 IDLE SHALL drive cmd_ready=1, mode_sel=0001 and pos_sel=0010, holding position.
REQ-023 A command SHALL be accepted when cmd_valid && cmd_ready: latch target_pos and cmd_mode, clear fault, and enter CRUISE next cycle.
REQ-024 cmd_ready SHALL be 0 outside IDLE; cmd_valid outside IDLE SHALL be ignored.
REQ-025 In CRUISE, dist SHALL be the unsigned |target - cur_pos| computed in WIDTH+1 bits with no wrap-around, and dir SHALL equal (target < cur_pos).
REQ-026 In CRUISE, mode_sel SHALL be combinational: the fastest tier not above the latched mode whose speed is <= dist, or 0001 if dist==0, so no cycle overshoots.
REQ-027 pos_sel SHALL be 0010 in all states except INIT.
REQ-028 CRUISE with dist==0 SHALL go to ARRIVE.
REQ-029 ARRIVE SHALL drive mode_sel=0001 and arrived=1 for one cycle, then go to IDLE.
REQ-030 abort in CRUISE SHALL go to IDLE, with mode_sel=0001 from the next cycle and no arrived pulse; if abort and dist==0 occur in the same cycle, abort wins.
REQ-031 A target equal to cur_pos at acceptance SHALL give CRUISE for 1 cycle, then ARRIVE.
REQ-032 busy SHALL be 1 in CRUISE and ARRIVE.

Reset
REQ-033 While rst_n=0, the state SHALL be INIT, cmd_ready/busy/arrived/fault/dir=0, latched target and mode=0, and the timeout counter=0.
REQ-034 Reset asserted mid-move SHALL abandon the move with no arrived pulse.

Configuration
REQ-035 NAV_TIMEOUT_EN defined: a counter SHALL clear on command acceptance and increment each CRUISE cycle; reaching TIMEOUT SHALL set fault=1 and go to IDLE with no arrived pulse.
REQ-036 NAV_TIMEOUT_EN undefined: no counter SHALL exist and fault SHALL be tied to 0.

Structure
REQ-037 Package nav_pkg SHALL hold the state enum, the one-hot constants MODE_ZERO/ATTACK/DEFENSE/STEALTH and POS_RESET/POS_ACCUM, and the cmd_mode encodings.
REQ-038 A combinational sub-module nav_tier_select SHALL map (dist, latched mode) to mode_sel.

Verification
REQ-039 Reset release: mode_sel=0001 and pos_sel=0001 for 1 cycle, then IDLE with cmd_ready=1.
REQ-040 From cur 0, target 37 in attack mode: 2 attack cycles, 1 defense cycle, 1 stealth cycle, then arrived pulse with cur=37 and no overshoot.
REQ-041 From cur 100, target 95 in defense mode: dir=1, 1 defense cycle, 1 stealth cycle, then arrived with cur=95.
REQ-042 Abort in the 3rd CRUISE cycle: next cycle IDLE with mode_sel=0001 and no arrived; a cmd_valid held during the move is not accepted until IDLE.
REQ-043 NAV_TIMEOUT_EN with TIMEOUT=3 and target 100 in stealth mode: fault=1 after 3 CRUISE cycles, then IDLE; the next command clears fault.
REQ-044 Target equal to cur_pos: arrived pulse 2 cycles after acceptance.
